pulse_scan_ctrl: RTL and testbench
==================================

# pulse_scan_ctrl

Time-multiplexed controller that shares one pulse-width measurement datapath between `N_CH` synchronous pulse inputs. On `start` it visits each channel in turn. Per channel it arms, measures `PULSES` complete high pulses, records minimum and maximum width, reports one result record, then moves to the next channel. It sits between the board signal inputs and the diagnostic/status register bank that consumes min/max widths.

## Interface
- `N_CH`, default 4: number of pulse inputs (≥2).
- `N_BITS`, default 8: width counter / result width.
- `PULSES`, default 16: complete pulses measured per channel (1..255).
- `TIMEOUT`, default 65535: max cycles spent on one channel (≥4); `T_BITS` = clog2(TIMEOUT+1).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep of all channels; ignored while `busy`.
- `abort` in 1: cancel sweep; return to IDLE.
- `pulse_in` in N_CH: pulse inputs, already synchronous to `clk`.
- `busy` out 1: sweep in progress.
- `ch_sel` out clog2(N_CH): channel currently connected to the datapath.
- `res_valid` out 1: one-cycle strobe, result record valid.
- `res_ch` out clog2(N_CH): channel of record.
- `res_min`, `res_max` out N_BITS: min/max high width in clk cycles.
- `res_count` out 8: complete pulses measured.
- `res_timeout` out 1: channel ended by timeout.
- `done` out 1: one-cycle strobe, sweep complete.

## Operation
- States: IDLE, ARM, WAIT_HIGH, COUNT, REPORT.
- IDLE: `start`=1 → ARM, `ch_sel`=0, `busy`=1.
- ARM: clear width counter, pulse count, and timeout counter. Set min=all-ones, max=0. Selected input 0 → WAIT_HIGH. A pulse already high on entry is never measured.
- WAIT_HIGH: input 1 → COUNT, width=1.
- COUNT: input 1 → width+1, saturating at 2^N_BITS−1.
  - Input 0 → pulse complete: min=min(min,width), max=max(max,width), count+1.
  - count reaching `PULSES` → REPORT; otherwise → WAIT_HIGH.
- Timeout counter increments every cycle in ARM/WAIT_HIGH/COUNT. Reaching TIMEOUT−1 → REPORT with `res_timeout`=1. Any in-progress pulse is discarded.
- REPORT: `res_valid`=1, with `res_ch`/`res_min`/`res_max`/`res_count`/`res_timeout` registered and held until the next REPORT.
  - Then `ch_sel` = N_CH−1 → IDLE, `done`=1, `busy`=0.
  - Else `ch_sel`+1 → ARM.
- Zero pulses measured: `res_min`=all-ones, `res_max`=0, `res_count`=0.
- Saturated width: reported as all-ones; no wrap.
- `abort` (any non-IDLE state) → IDLE next cycle. No `res_valid`, no `done`. `busy`=0 and `ch_sel`=0. `abort` outranks a completing pulse or timeout in the same cycle.
- `start` and `abort` together in IDLE → stay IDLE.
- `reset` (any time, including mid-sweep) → IDLE next edge. All outputs 0; min/max registers return to init values.

## Timing
- `start` sampled at cycle t → `busy`=1, state ARM at t+1.
- A pulse high for H consecutive samples measures exactly H (saturating).
- Final falling-edge sample at cycle f → `res_valid`=1 during f+1. The next channel is in ARM at f+2, or `done`=1 with `busy`=0 at f+2 for the last channel.
- Timeout: channel entered ARM at cycle a → REPORT at a+TIMEOUT.
- All outputs registered; no combinational path from `pulse_in` to outputs.

## Structure
- Package `pulse_scan_pkg`:
  - `state_t` enum (IDLE, ARM, WAIT_HIGH, COUNT, REPORT);
  - `ch_w(N_CH)` width function;
  - `PCNT_W`=8 constant.
- Sub-module `pulse_width_meas`: width counter with saturation, min/max registers, pulse counter, and clear/enable from the FSM. The top holds FSM, channel mux, timeout counter and result registers.

## Test plan
- N_CH=2, PULSES=3, TIMEOUT=1000; ch0 highs of 5,2,9 cycles (lows 4) → `res_ch`=0, min=2, max=9, count=3, timeout=0. Then ch1 is measured and `done` is pulsed.
- ch0 held high at `start`, then highs of 3,3,3 → first partial pulse ignored; min=max=3, count=3.
- N_BITS=4, one 20-cycle high → width saturates; `res_max`=15, no wrap.
- ch1 constant 0 → REPORT at ARM+1000 with `res_timeout`=1, count=0, min=15/255 (all-ones), max=0.
- `abort` mid-COUNT on ch0 → IDLE next cycle, `busy`=0, no `res_valid`/`done`. A new `start` then runs a full sweep.
- `reset` during ch1 WAIT_HIGH → all outputs 0 next cycle; `start` during `busy` ignored (no restart of `ch_sel`).

Source files
------------

// File: rtl/pulse_scan_pkg.sv
// rtl/pulse_scan_pkg.sv - shared types and constants for the pulse scan controller
package pulse_scan_pkg;

    // Sweep FSM states
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_HIGH,
        COUNT,
        REPORT
    } state_t;

    // Width of the pulse counter and of the reported count
    localparam int PCNT_W = 8;

    // Bits needed to address n channels; never narrower than one bit
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_width_meas.sv
// rtl/pulse_width_meas.sv - shared width counter with min/max tracking and pulse count
//
// The FSM in the top drives the strobes: clear while arming, first on the
// first high sample, extend on every further high sample, complete on the
// falling sample. The *_upd outputs show the statistics as they will look
// once the current cycle's completion (if any) has been folded in, so the
// top can register a result in the same cycle the last pulse ends.
module pulse_width_meas
    import pulse_scan_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_first,
    input  logic                i_extend,
    input  logic                i_complete,
    output logic [N_BITS-1:0]   o_min_upd,
    output logic [N_BITS-1:0]   o_max_upd,
    output logic [PCNT_W-1:0]   o_count_upd
);

    localparam logic [N_BITS-1:0] W_MAX = '1;

    logic [N_BITS-1:0] r_width;
    logic [N_BITS-1:0] r_min;
    logic [N_BITS-1:0] r_max;
    logic [PCNT_W-1:0] r_count;

    // Fold the width of a pulse finishing this cycle into min/max/count
    always_comb begin
        o_min_upd   = r_min;
        o_max_upd   = r_max;
        o_count_upd = r_count;
        if (i_complete) begin
            if (r_width < r_min) begin
                o_min_upd = r_width;
            end
            if (r_width > r_max) begin
                o_max_upd = r_width;
            end
            o_count_upd = r_count + PCNT_W'(1);
        end
    end

    // Width counter saturates at all-ones; statistics commit on completion
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_width <= '0;
            r_min   <= W_MAX;
            r_max   <= '0;
            r_count <= '0;
        end else begin
            if (i_first) begin
                r_width <= N_BITS'(1);
            end else if (i_extend && (r_width != W_MAX)) begin
                r_width <= r_width + N_BITS'(1);
            end
            if (i_complete) begin
                r_min   <= o_min_upd;
                r_max   <= o_max_upd;
                r_count <= o_count_upd;
            end
        end
    end

endmodule

// File: rtl/pulse_scan_ctrl.sv
// rtl/pulse_scan_ctrl.sv - time-multiplexed pulse width scanner over N_CH inputs
//
// Visits each channel in turn, measures PULSES complete high pulses (or
// gives up after TIMEOUT cycles) and emits one registered result record per
// channel. A pulse already high when the channel is armed is skipped.
module pulse_scan_ctrl
    import pulse_scan_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int N_BITS  = 8,
    parameter int PULSES  = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [N_CH-1:0]           i_pulse_in,
    output logic                      o_busy,
    output logic [ch_w(N_CH)-1:0]     o_ch_sel,
    output logic                      o_res_valid,
    output logic [ch_w(N_CH)-1:0]     o_res_ch,
    output logic [N_BITS-1:0]         o_res_min,
    output logic [N_BITS-1:0]         o_res_max,
    output logic [PCNT_W-1:0]         o_res_count,
    output logic                      o_res_timeout,
    output logic                      o_done
);

    localparam int CH_W   = ch_w(N_CH);
    localparam int T_BITS = $clog2(TIMEOUT + 1);

    localparam logic [T_BITS-1:0] T_LAST   = T_BITS'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [PCNT_W-1:0] P_TARGET = PCNT_W'(PULSES);

    state_t              r_state;
    logic [T_BITS-1:0]   r_tcnt;
    logic [CH_W-1:0]     r_ch_sel;
    logic                r_busy;
    logic                r_res_valid;
    logic [CH_W-1:0]     r_res_ch;
    logic [N_BITS-1:0]   r_res_min;
    logic [N_BITS-1:0]   r_res_max;
    logic [PCNT_W-1:0]   r_res_count;
    logic                r_res_timeout;
    logic                r_done;

    logic                w_in;
    logic                w_active;
    logic                w_clear;
    logic                w_first;
    logic                w_extend;
    logic                w_complete;
    logic                w_finish;
    logic                w_expire;
    logic [N_BITS-1:0]   w_min_upd;
    logic [N_BITS-1:0]   w_max_upd;
    logic [PCNT_W-1:0]   w_count_upd;

    // Channel mux: only the selected input reaches the datapath
    assign w_in       = i_pulse_in[r_ch_sel];

    assign w_active   = (r_state == ARM) || (r_state == WAIT_HIGH) || (r_state == COUNT);
    assign w_clear    = (r_state == ARM);
    assign w_first    = (r_state == WAIT_HIGH) && w_in;
    assign w_extend   = (r_state == COUNT) && w_in;
    assign w_complete = (r_state == COUNT) && !w_in && !i_abort;

    // Last required pulse ending wins over a timeout landing in the same cycle
    assign w_finish   = w_complete && (w_count_upd == P_TARGET);
    assign w_expire   = w_active && (r_tcnt == T_LAST);

    pulse_width_meas #(
        .N_BITS (N_BITS)
    ) u_meas (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_clear),
        .i_first     (w_first),
        .i_extend    (w_extend),
        .i_complete  (w_complete),
        .o_min_upd   (w_min_upd),
        .o_max_upd   (w_max_upd),
        .o_count_upd (w_count_upd)
    );

    // Sweep FSM with timeout counter, channel select and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_tcnt        <= '0;
            r_ch_sel      <= '0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_min     <= '0;
            r_res_max     <= '0;
            r_res_count   <= '0;
            r_res_timeout <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state  <= ARM;
                        r_ch_sel <= '0;
                        r_busy   <= 1'b1;
                        r_tcnt   <= '0;
                    end
                end
                ARM, WAIT_HIGH, COUNT: begin
                    if (i_abort) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_ch_sel <= '0;
                    end else if (w_finish || w_expire) begin
                        r_state       <= REPORT;
                        r_res_valid   <= 1'b1;
                        r_res_ch      <= r_ch_sel;
                        r_res_min     <= w_min_upd;
                        r_res_max     <= w_max_upd;
                        r_res_count   <= w_count_upd;
                        r_res_timeout <= !w_finish;
                    end else begin
                        r_tcnt <= r_tcnt + T_BITS'(1);
                        case (r_state)
                            ARM:       if (!w_in) r_state <= WAIT_HIGH;
                            WAIT_HIGH: if (w_in)  r_state <= COUNT;
                            COUNT:     if (!w_in) r_state <= WAIT_HIGH;
                            default:   r_state <= IDLE;
                        endcase
                    end
                end
                REPORT: begin
                    if (i_abort) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_ch_sel <= '0;
                    end else if (r_ch_sel == CH_LAST) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_ch_sel <= '0;
                    end else begin
                        r_state  <= ARM;
                        r_ch_sel <= r_ch_sel + CH_W'(1);
                        r_tcnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_ch_sel      = r_ch_sel;
    assign o_res_valid   = r_res_valid;
    assign o_res_ch      = r_res_ch;
    assign o_res_min     = r_res_min;
    assign o_res_max     = r_res_max;
    assign o_res_count   = r_res_count;
    assign o_res_timeout = r_res_timeout;
    assign o_done        = r_done;

endmodule

// File: tb/tb_pulse_scan_ctrl.sv
// tb/tb_pulse_scan_ctrl.sv - self-checking bench for pulse_scan_ctrl
module tb_pulse_scan_ctrl;
    import pulse_scan_pkg::*;

    localparam int N_CH    = 2;
    localparam int N_BITS  = 4;
    localparam int PULSES  = 3;
    localparam int TIMEOUT = 1000;
    localparam int WLEN    = 2200;
    localparam int WMAX    = (1 << N_BITS) - 1;
    localparam int LO      = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [N_CH-1:0]       pulse_in = '0;
    logic                  busy;
    logic [0:0]            ch_sel;
    logic                  res_valid;
    logic [0:0]            res_ch;
    logic [N_BITS-1:0]     res_min;
    logic [N_BITS-1:0]     res_max;
    logic [7:0]            res_count;
    logic                  res_timeout;
    logic                  done;

    pulse_scan_ctrl #(
        .N_CH(N_CH), .N_BITS(N_BITS), .PULSES(PULSES), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .i_pulse_in(pulse_in), .o_busy(busy), .o_ch_sel(ch_sel),
        .o_res_valid(res_valid), .o_res_ch(res_ch), .o_res_min(res_min),
        .o_res_max(res_max), .o_res_count(res_count),
        .o_res_timeout(res_timeout), .o_done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rel; int ch; int mn; int mx; int cnt; int tmo;
    } ev_t;

    typedef struct {
        int pre0; int h0a; int h0b; int h0c; int hi1; int lo1;
        int mn0; int mx0; int c0; int t0;
        int mn1; int mx1; int c1; int t1;
        int rel0;
    } vec_t;

    bit   wave [N_CH][WLEN];
    int   sweep_base = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  got_q[$];
    int   done_q[$];
    ev_t  exp_q[$];
    int   exp_done;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive the selected waveform and record result/done strobes away from posedge
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                int idx;
                idx = cyc - sweep_base;
                pulse_in[c] = (idx >= 0 && idx < WLEN) ? wave[c][idx] : 1'b0;
            end
            if (res_valid) begin
                ev_t e;
                e.rel = cyc - sweep_base; e.ch = int'(res_ch);
                e.mn = int'(res_min); e.mx = int'(res_max);
                e.cnt = int'(res_count); e.tmo = int'(res_timeout);
                got_q.push_back(e);
            end
            if (done) done_q.push_back(cyc - sweep_base);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: scan the channel's samples from its arm cycle using the pulse rules
    function automatic void model_channel(input int ch, input int a, output int endk,
                                          output int mn, output int mx, output int cnt,
                                          output int tmo);
        int run;
        bit armed;
        bit b;
        int w;
        run = 0; armed = 0;
        mn = WMAX; mx = 0; cnt = 0; tmo = 1; endk = TIMEOUT - 1;
        for (int k = 0; k < TIMEOUT; k++) begin
            b = (a + k < WLEN) ? wave[ch][a + k] : 1'b0;
            if (!armed) begin
                if (!b) armed = 1;
            end else if (b) begin
                run++;
            end else if (run > 0) begin
                w = (run > WMAX) ? WMAX : run;
                if (w < mn) mn = w;
                if (w > mx) mx = w;
                cnt++;
                run = 0;
                if (cnt == PULSES) begin
                    endk = k; tmo = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic build_expect();
        int a, endk, mn, mx, cnt, tmo;
        ev_t e;
        exp_q.delete();
        a = 1;
        for (int c = 0; c < N_CH; c++) begin
            model_channel(c, a, endk, mn, mx, cnt, tmo);
            e.rel = a + endk + 1; e.ch = c; e.mn = mn; e.mx = mx; e.cnt = cnt; e.tmo = tmo;
            exp_q.push_back(e);
            a = a + endk + 2;
        end
        exp_done = a;
    endtask

    task automatic clear_waves();
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < WLEN; i++) wave[c][i] = 1'b0;
    endtask

    task automatic fill_directed(input vec_t v);
        int idx;
        int hs[3];
        clear_waves();
        hs[0] = v.h0a; hs[1] = v.h0b; hs[2] = v.h0c;
        idx = 1;
        if (v.pre0 > 0) wave[0][0] = 1'b1;
        for (int i = 0; i < v.pre0; i++) begin wave[0][idx] = 1'b1; idx++; end
        for (int p = 0; p < 3; p++) begin
            if (hs[p] == 0) break;
            idx += LO;
            for (int i = 0; i < hs[p]; i++) begin wave[0][idx] = 1'b1; idx++; end
        end
        if (v.hi1 > 0)
            for (int i = 0; i < WLEN; i++)
                wave[1][i] = ((i % (v.hi1 + v.lo1)) < v.hi1);
    endtask

    task automatic fill_random();
        int mode, i, len;
        bit lvl;
        clear_waves();
        for (int c = 0; c < N_CH; c++) begin
            mode = $urandom_range(0, 5);
            if (mode != 0) begin
                lvl = (mode == 1);
                i = 0;
                while (i < WLEN) begin
                    if (lvl) len = $urandom_range(1, 20);
                    else if (mode == 2) len = $urandom_range(1, 400);
                    else len = $urandom_range(1, 6);
                    for (int k = 0; k < len && i < WLEN; k++) begin wave[c][i] = lvl; i++; end
                    lvl = !lvl;
                end
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        sweep_base = cyc;
        got_q.delete();
        done_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - sweep_base < rel) @(negedge clk);
    endtask

    task automatic run_sweep(input string tag);
        int guard;
        do_start();
        check({tag, "_busy_arm"}, int'(busy), 1);
        guard = 0;
        while (done_q.size() == 0 && guard < WLEN) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_seen"}, done_q.size(), 1);
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_chsel_end"}, int'(ch_sel), 0);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_nres"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_r%0d_cyc", tag, i), got_q[i].rel, exp_q[i].rel);
            check($sformatf("%s_r%0d_ch", tag, i), got_q[i].ch, exp_q[i].ch);
            check($sformatf("%s_r%0d_min", tag, i), got_q[i].mn, exp_q[i].mn);
            check($sformatf("%s_r%0d_max", tag, i), got_q[i].mx, exp_q[i].mx);
            check($sformatf("%s_r%0d_cnt", tag, i), got_q[i].cnt, exp_q[i].cnt);
            check($sformatf("%s_r%0d_tmo", tag, i), got_q[i].tmo, exp_q[i].tmo);
        end
        if (done_q.size() > 0) check({tag, "_done_cyc"}, done_q[0], exp_done);
    endtask

    initial begin
        int emn[2], emx[2], ec[2], et[2];
        string tag;

        //           pre h0a h0b h0c hi1 lo1 mn0 mx0 c0 t0  mn1 mx1 c1 t1 rel0
        vecs[0] = '{0,   5,  2,  9,  3,  4,  2,  9,  3, 0,  3,  3,  3, 0, 30};
        vecs[1] = '{6,   3,  3,  3,  7,  2,  3,  3,  3, 0,  7,  7,  3, 0, 29};
        vecs[2] = '{0,  20,  1,  4,  0,  0,  1, 15,  3, 0, 15,  0,  0, 1, 39};
        vecs[3] = '{0,   0,  0,  0,  1,  1, 15,  0,  0, 1,  1,  1,  3, 0, 1001};
        vecs[4] = '{0,   2,  0,  0, 15,  3,  2,  2,  1, 1, 15, 15,  3, 0, 1001};
        vecs[5] = '{0,  16, 15, 14, 16,  2, 14, 15,  3, 0, 15, 15,  3, 0, 59};

        clear_waves();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_chsel", int'(ch_sel), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_min", int'(res_min), 0);
        check("rst_count", int'(res_count), 0);
        reset = 1'b0;

        // start together with abort in IDLE is ignored
        @(negedge clk);
        got_q.delete(); done_q.delete();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("startabort_nres", got_q.size() + done_q.size(), 0);

        // abort in the middle of the first ch0 pulse
        fill_directed(vecs[0]);
        do_start();
        wait_rel(7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_chsel", int'(ch_sel), 0);
        wait_rel(80);
        check("abort_no_res", got_q.size(), 0);
        check("abort_no_done", done_q.size(), 0);

        // directed table, starting with the sweep after the abort
        for (int v = 0; v < 6; v++) begin
            tag = $sformatf("vec%0d", v);
            fill_directed(vecs[v]);
            run_sweep(tag);
            emn[0] = vecs[v].mn0; emx[0] = vecs[v].mx0; ec[0] = vecs[v].c0; et[0] = vecs[v].t0;
            emn[1] = vecs[v].mn1; emx[1] = vecs[v].mx1; ec[1] = vecs[v].c1; et[1] = vecs[v].t1;
            check({tag, "_nres"}, got_q.size(), 2);
            for (int c = 0; c < 2 && c < got_q.size(); c++) begin
                check($sformatf("%s_c%0d_ch", tag, c), got_q[c].ch, c);
                check($sformatf("%s_c%0d_min", tag, c), got_q[c].mn, emn[c]);
                check($sformatf("%s_c%0d_max", tag, c), got_q[c].mx, emx[c]);
                check($sformatf("%s_c%0d_cnt", tag, c), got_q[c].cnt, ec[c]);
                check($sformatf("%s_c%0d_tmo", tag, c), got_q[c].tmo, et[c]);
            end
            if (got_q.size() > 0) check({tag, "_rel0"}, got_q[0].rel, vecs[v].rel0);
        end

        // start while busy is ignored; reset during ch1 WAIT_HIGH clears outputs
        fill_directed(vecs[0]);
        for (int i = 0; i < WLEN; i++) wave[1][i] = 1'b0;
        do_start();
        wait_rel(40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busystart_chsel", int'(ch_sel), 1);
        check("busystart_busy", int'(busy), 1);
        check("busystart_nres", got_q.size(), 1);
        wait_rel(50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_chsel", int'(ch_sel), 0);
        check("midrst_valid", int'(res_valid), 0);
        check("midrst_min", int'(res_min), 0);
        check("midrst_max", int'(res_max), 0);
        check("midrst_count", int'(res_count), 0);
        check("midrst_done", int'(done), 0);

        // randomized sweeps against the reference model
        for (int r = 0; r < 10; r++) begin
            tag = $sformatf("rnd%0d", r);
            fill_random();
            build_expect();
            run_sweep(tag);
            compare_model(tag);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
